// File: rtl/shot_history_register.sv
// Shot history register: debounced-edge commit of attack coordinates into a
// circular history of the last DEPTH accepted shots, with repeat rejection.
// Ports: CLK, NRST (sync active-low), COORD, SETBTN (level), CLEAR;
//   ACCEPT/REJECT one-cycle pulses, MATCHTEST/REPEAT comb compares,
//   LAST/LAST_VALID last accepted shot, COUNT/FULL history occupancy.
module shot_history_register #(
   parameter int COORD_W = 6,
   parameter int DEPTH   = 8,
   parameter bit WRAP    = 1'b0
) (
   input  logic                       CLK,
   input  logic                       NRST,
   input  logic [COORD_W-1:0]         COORD,
   input  logic                       SETBTN,
   input  logic                       CLEAR,
   output logic                       ACCEPT,
   output logic                       REJECT,
   output logic                       MATCHTEST,
   output logic                       REPEAT,
   output logic [COORD_W-1:0]         LAST,
   output logic                       LAST_VALID,
   output logic [$clog2(DEPTH+1)-1:0] COUNT,
   output logic                       FULL
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      WAIT_REL
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic                 setbtn_q;
   logic                 req;
   logic [COORD_W-1:0]   cap;
   logic [COORD_W-1:0]   mem [DEPTH];
   logic [DEPTH-1:0]     vld;
   logic [PW-1:0]        ptr;
   logic [PW-1:0]        ptr_inc;
   logic [CW-1:0]        count;
   logic                 full;
   logic                 cap_rep;
   logic                 coord_rep;
   logic                 do_acc;
   logic                 do_rej;
   logic                 do_wr;

   assign req     = SETBTN & ~setbtn_q;
   assign full    = (count == CW'(DEPTH));
   assign ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);

   // Invalid slots never match, so stale data after clear is harmless.
   always_comb begin
      cap_rep   = 1'b0;
      coord_rep = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld[i] && (mem[i] == cap))   cap_rep   = 1'b1;
         if (vld[i] && (mem[i] == COORD)) coord_rep = 1'b1;
      end
   end

   // State register
   always_ff @(posedge CLK) begin
      if (!NRST) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic; CLEAR overrides any commit in flight
   always_comb begin
      state_nx = state;
      if (CLEAR) begin
         state_nx = SETBTN ? WAIT_REL : IDLE;
      end else begin
         unique case (state)
            IDLE:     if (req) state_nx = EVAL;
            EVAL:     state_nx = WAIT_REL;
            WAIT_REL: if (!SETBTN) state_nx = IDLE;
            default:  state_nx = IDLE;
         endcase
      end
   end

   // Commit decision, taken on the captured coordinate
   always_comb begin
      do_acc = 1'b0;
      do_rej = 1'b0;
      do_wr  = 1'b0;
      if ((state == EVAL) && !CLEAR) begin
         if (cap_rep) begin
            do_rej = 1'b1;
         end else if (!full || WRAP) begin
            do_wr  = 1'b1;
            do_acc = 1'b1;
         end else begin
            do_rej = 1'b1;
         end
      end
   end

   assign REPEAT    = coord_rep;
   assign MATCHTEST = LAST_VALID && (COORD == LAST);
   assign FULL      = full;
   assign COUNT     = count;

   // Button history resets high so a press held through reset is ignored.
   always_ff @(posedge CLK) begin
      if (!NRST) begin
         setbtn_q   <= 1'b1;
         cap        <= '0;
         vld        <= '0;
         ptr        <= '0;
         count      <= '0;
         LAST       <= '0;
         LAST_VALID <= 1'b0;
         ACCEPT     <= 1'b0;
         REJECT     <= 1'b0;
      end else begin
         setbtn_q <= SETBTN;
         ACCEPT   <= do_acc;
         REJECT   <= do_rej;
         if ((state == IDLE) && req && !CLEAR) cap <= COORD;
         if (CLEAR) begin
            vld        <= '0;
            ptr        <= '0;
            count      <= '0;
            LAST_VALID <= 1'b0;
         end else if (do_wr) begin
            vld[ptr]   <= 1'b1;
            ptr        <= ptr_inc;
            LAST       <= cap;
            LAST_VALID <= 1'b1;
            if (!full) count <= count + CW'(1);
         end
      end
   end

   // When full, the pointer sits on the oldest entry, so wrap overwrites it.
   always_ff @(posedge CLK) begin
      if (do_wr) mem[ptr] <= cap;
   end

endmodule

// File: doc/shot_history_register.md
Name: shot_history_register

Overview:
- Clocked, parametrised successor to the 6-bit last-valid-attack latch register.
- Stores the last DEPTH accepted attack coordinates in a circular history.
- Debounced-edge commit from SETBTN: a new coordinate is accepted only if it is not already in the history, otherwise the commit is rejected.
- Sits between the coordinate switches and the game-turn FSM, which consumes the ACCEPT/REJECT pulses.

Parameters:
- COORD_W, 6: coordinate width in bits.
- DEPTH, 8: number of history entries; must be ≥1.
- WRAP, 0: when history is full, 1 overwrites the oldest entry, 0 rejects the commit.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- NRST  in  1  reset, synchronous, active-low.
- COORD  in  COORD_W  currently selected coordinate; synchronous to CLK.
- SETBTN  in  1  commit request, level; each low→high transition is one request.
- CLEAR  in  1  synchronous history clear.
- ACCEPT  out  1  one-cycle pulse: coordinate stored.
- REJECT  out  1  one-cycle pulse: commit refused (repeat, or full with WRAP=0).
- MATCHTEST  out  1  combinational: LAST_VALID and COORD==LAST.
- REPEAT  out  1  combinational: COORD equals any valid history entry.
- LAST  out  COORD_W  most recently accepted coordinate.
- LAST_VALID  out  1  LAST holds an accepted coordinate.
- COUNT  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- FULL  out  1  COUNT==DEPTH.

Behaviour:
- Reset (NRST=0 at a clock edge):
  - state=IDLE; all entry valid bits=0; write pointer=0; COUNT=0.
  - LAST=0; LAST_VALID=0; ACCEPT=REJECT=0.
  - Registered SETBTN history bit = 1, so a button held through reset causes no commit.
- Edge detect: request = SETBTN & ~SETBTN_q, where SETBTN_q is SETBTN registered each cycle.
- FSM:
  - IDLE: a request at edge t captures COORD into CAP and moves to EVAL.
  - EVAL, at edge t+1:
    - CAP repeat → REJECT=1.
    - Else not full → write CAP at the pointer; pointer wraps DEPTH-1→0; COUNT+1; LAST=CAP; LAST_VALID=1; ACCEPT=1.
    - Else full and WRAP=1 → overwrite the oldest entry (at the pointer); advance the pointer; COUNT stays DEPTH; LAST=CAP; ACCEPT=1.
    - Else full and WRAP=0 → REJECT=1.
    - Always → WAIT_REL.
  - WAIT_REL: stays until SETBTN=0 is sampled, then → IDLE.
- Pulses: ACCEPT/REJECT are high exactly one cycle, during the cycle after edge t+1. They are mutually exclusive.
- Latency: pulse visible 2 edges after the sampled rising SETBTN.
- Repeat check in EVAL uses CAP, not the live COORD. COORD changes after edge t do not affect the decision.
- CLEAR=1 at an edge:
  - Clears valid bits, pointer, COUNT and LAST_VALID.
  - Suppresses any EVAL write and pulse.
  - Next state = WAIT_REL if SETBTN=1, else IDLE.
  - CLEAR has priority over commit.
- NRST has priority over CLEAR.
- REPEAT and MATCHTEST ignore invalid entries. After reset, COORD=0 gives REPEAT=0 and MATCHTEST=0.
- Entry order: COUNT<DEPTH → entries 0..COUNT-1 are valid; the oldest entry is always at the pointer once full.

Test Plan:
- Reset, SETBTN held high across reset release, COORD=6'h05 → no ACCEPT/REJECT; COUNT=0 until release and re-press.
- Press with COORD=6'h05 → ACCEPT 2 edges later; COUNT=1; LAST=6'h05; MATCHTEST=1; press again with 6'h05 → REJECT, COUNT=1.
- DEPTH=8, WRAP=0: accept 8 distinct coords 0..7 → FULL=1; press 6'h20 → REJECT, COUNT=8.
- WRAP=1, same fill, press 6'h20 → ACCEPT; REPEAT for COORD=0 now 0, for 6'h20 now 1; COUNT=8.
- CLEAR asserted in the EVAL cycle of a valid commit → no pulse; COUNT=0; LAST_VALID=0; no commit while SETBTN stays high.
- COORD changed from 6'h05 to 6'h09 one cycle after the press edge → 6'h05 stored, LAST=6'h05.
